// File: rtl/grayscale_pkg.sv
// ---------------------------------------------------------------------------
// grayscale_pkg
// Shared constants and types for the RGB565-to-grayscale custom instruction.
//   GRAY_COEF_R/G/B : luma weights (they sum to 256, so >>8 normalises)
//   PIXELS_PER_CALL : pixels converted per CPU call
//   state_t         : sequencer FSM states
// ---------------------------------------------------------------------------
package grayscale_pkg;

  localparam int unsigned GRAY_COEF_R     = 54;
  localparam int unsigned GRAY_COEF_G     = 183;
  localparam int unsigned GRAY_COEF_B     = 19;
  localparam int unsigned PIXELS_PER_CALL = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rgb565_to_gray.sv
// ---------------------------------------------------------------------------
// rgb565_to_gray
// Purely combinational RGB565 pixel to 8-bit grey converter.
//   pixel [15:0] in  : R5 = [15:11], G6 = [10:5], B5 = [4:0]
//   gray  [7:0]  out : (54*R8 + 183*G8 + 19*B8) >> 8
// Fields are widened to 8 bits by MSB replication so full-scale inputs
// map to full-scale 8-bit values (white -> 0xFF).
// ---------------------------------------------------------------------------
module rgb565_to_gray
  import grayscale_pkg::*;
(
  input  logic [15:0] pixel,
  output logic [7:0]  gray
);

  logic [7:0]  r8;
  logic [7:0]  g8;
  logic [7:0]  b8;
  logic [15:0] wsum;
  logic [7:0]  unused_frac;

  assign r8 = {pixel[15:11], pixel[15:13]};
  assign g8 = {pixel[10:5],  pixel[10:9]};
  assign b8 = {pixel[4:0],   pixel[4:2]};

  // Coefficients sum to 256, so the 16-bit sum cannot overflow.
  assign wsum = 16'(GRAY_COEF_R) * {8'd0, r8}
              + 16'(GRAY_COEF_G) * {8'd0, g8}
              + 16'(GRAY_COEF_B) * {8'd0, b8};

  // The fractional byte is discarded by the >> 8 normalisation.
  assign {gray, unused_frac} = wsum;

endmodule

// File: rtl/grayscale_ci_sequencer.sv
// ---------------------------------------------------------------------------
// grayscale_ci_sequencer
// Custom-instruction controller that pushes four packed RGB565 pixels, one
// per cycle, through a single shared grey converter.
//   clock        in  system clock
//   reset        in  synchronous active-low reset
//   start        in  CI start strobe
//   iseId  [7:0] in  CI identifier of the issued instruction
//   valueA [31:0] in p0 = [15:0], p1 = [31:16]
//   valueB [31:0] in p2 = [15:0], p3 = [31:16]
//   done         out one-cycle completion pulse
//   result [31:0] out packed grey bytes g3..g0, zero whenever done is low
// ---------------------------------------------------------------------------
module grayscale_ci_sequencer
  import grayscale_pkg::*;
#(
  parameter logic [7:0] customId = 8'h0C
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] LAST_IDX = 2'(PIXELS_PER_CALL - 1);

  state_t      state_q,  state_d;
  logic [1:0]  idx_q,    idx_d;
  logic [63:0] opnd_q,   opnd_d;
  logic [31:0] acc_q,    acc_d;
  logic        done_q,   done_d;
  logic [31:0] result_q, result_d;

  logic [15:0] cur_pixel;
  logic [7:0]  cur_gray;
  logic [31:0] acc_merged;

  // Pixel selected by the running index feeds the one shared converter.
  always_comb begin
    cur_pixel = opnd_q[15:0];
    case (idx_q)
      2'd0:    cur_pixel = opnd_q[15:0];
      2'd1:    cur_pixel = opnd_q[31:16];
      2'd2:    cur_pixel = opnd_q[47:32];
      default: cur_pixel = opnd_q[63:48];
    endcase
  end

  rgb565_to_gray u_conv (
    .pixel (cur_pixel),
    .gray  (cur_gray)
  );

  // Accumulator with the current grey byte dropped into lane [idx].
  always_comb begin
    acc_merged = acc_q;
    case (idx_q)
      2'd0:    acc_merged[7:0]   = cur_gray;
      2'd1:    acc_merged[15:8]  = cur_gray;
      2'd2:    acc_merged[23:16] = cur_gray;
      default: acc_merged[31:24] = cur_gray;
    endcase
  end

  // Next-state logic. done/result are computed one edge early so the
  // outputs come straight from flops and are high only in the DONE cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    result_d = 32'h0;
    case (state_q)
      IDLE: begin
        if (start && (iseId == customId)) begin
          opnd_d  = {valueB, valueA};
          idx_d   = 2'd0;
          acc_d   = 32'h0;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d = acc_merged;
        idx_d = idx_q + 2'd1;
        if (idx_q == LAST_IDX) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = acc_merged;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      opnd_q   <= 64'h0;
      acc_q    <= 32'h0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_grayscale_ci_sequencer.sv
// ---------------------------------------------------------------------------
// tb_grayscale_ci_sequencer
// Self-checking bench: a transaction-level model predicts done/result for
// every cycle; directed scenarios and a randomized phase drive the DUT.
// ---------------------------------------------------------------------------
module tb_grayscale_ci_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  iseId = 8'h00;
  logic [31:0] valueA = 32'h0;
  logic [31:0] valueB = 32'h0;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int doneCount = 0;

  // Model state: a call accepted at edge c completes after edge c+4 and the
  // block is free to accept again from edge c+6.
  bit          modelPending = 1'b0;
  int          acceptEdge = 0;
  int          nextOk = 0;
  logic [31:0] pendRes = 32'h0;
  logic        expDone = 1'b0;
  logic [31:0] expResult = 32'h0;

  grayscale_ci_sequencer dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .iseId  (iseId),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result)
  );

  always #5 clock = ~clock;

  // Reference conversion straight from the arithmetic definition.
  function automatic logic [7:0] refGray(input logic [15:0] p);
    int r, g, b, r8, g8, b8;
    r  = int'(p[15:11]);
    g  = int'(p[10:5]);
    b  = int'(p[4:0]);
    r8 = (r << 3) | (r >> 2);
    g8 = (g << 2) | (g >> 4);
    b8 = (b << 3) | (b >> 2);
    return 8'((54 * r8 + 183 * g8 + 19 * b8) / 256);
  endfunction

  function automatic logic [31:0] refCall(input logic [31:0] a, input logic [31:0] b);
    return {refGray(b[31:16]), refGray(b[15:0]), refGray(a[31:16]), refGray(a[15:0])};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] id,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start  = s;
    iseId  = id;
    valueA = a;
    valueB = b;
  endtask

  // Behavioural model, evaluated on every rising edge.
  always @(posedge clock) begin
    cyc++;
    expDone   = 1'b0;
    expResult = 32'h0;
    if (!reset) begin
      modelPending = 1'b0;
      nextOk       = 0;
    end else begin
      if (modelPending && cyc == acceptEdge + 4) begin
        expDone      = 1'b1;
        expResult    = pendRes;
        modelPending = 1'b0;
      end
      if (start && iseId == 8'h0C && cyc >= nextOk) begin
        modelPending = 1'b1;
        acceptEdge   = cyc;
        nextOk       = cyc + 6;
        pendRes      = refCall(valueA, valueB);
      end
    end
  end

  // Compare process: outputs are meaningful on every cycle after the first edge.
  always @(negedge clock) begin
    if (cyc > 0) begin
      checkOutput("done", {31'd0, done}, {31'd0, expDone});
      checkOutput("result", result, expResult);
      if (done === 1'b1) doneCount++;
    end
  end

  initial begin
    // Model pins against hand-computed values.
    checkOutput("pin_gray_red", {24'd0, refGray(16'hF800)}, 32'h0000_0035);
    checkOutput("pin_mixed", refCall(32'hF800_FFFF, 32'h001F_07E0), 32'h12B6_35FF);
    checkOutput("pin_zero", refCall(32'h0, 32'h0), 32'h0000_0000);
    checkOutput("pin_white", refCall(32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

    // Reset for 4 cycles, then idle.
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Directed call with literal expectation at the done cycle.
    doneCount = 0;
    applyStimulus(1'b1, 8'h0C, 32'hF800_FFFF, 32'h001F_07E0);
    applyStimulus(1'b0, 8'h0C, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (3) @(negedge clock);
    @(negedge clock);
    #1;
    checkOutput("lit_done_at5", {31'd0, done}, 32'd1);
    checkOutput("lit_result_at5", result, 32'h12B6_35FF);
    @(negedge clock);
    #1;
    checkOutput("lit_done_cleared", {31'd0, done}, 32'd0);
    checkOutput("lit_result_cleared", result, 32'h0);

    // Zero and white operands.
    applyStimulus(1'b1, 8'h0C, 32'h0, 32'h0);
    applyStimulus(1'b0, 8'h00, 32'h0, 32'h0);
    repeat (6) @(negedge clock);
    applyStimulus(1'b1, 8'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 8'h00, 32'h0, 32'h0);
    repeat (6) @(negedge clock);

    // start held for 8 cycles with operands changing: exactly two calls.
    doneCount = 0;
    applyStimulus(1'b1, 8'h0C, 32'hF800_FFFF, 32'h001F_07E0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'h0C, $urandom, $urandom);
    applyStimulus(1'b0, 8'h00, 32'h0, 32'h0);
    repeat (6) @(negedge clock);
    checkOutput("held_start_dones", doneCount, 32'd2);

    // Non-matching id never completes.
    doneCount = 0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h0B, $urandom, $urandom);
    applyStimulus(1'b0, 8'h00, 32'h0, 32'h0);
    repeat (6) @(negedge clock);
    checkOutput("wrong_id_dones", doneCount, 32'd0);

    // Reset mid-call drops it; a fresh call then completes.
    doneCount = 0;
    applyStimulus(1'b1, 8'h0C, 32'hF800_FFFF, 32'h001F_07E0);
    applyStimulus(1'b0, 8'h00, 32'h0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    checkOutput("reset_drop_dones", doneCount, 32'd0);
    applyStimulus(1'b1, 8'h0C, 32'h07E0_001F, 32'hFFFF_F800);
    applyStimulus(1'b0, 8'h00, 32'h0, 32'h0);
    repeat (6) @(negedge clock);
    checkOutput("fresh_call_dones", doneCount, 32'd1);

    // Randomized phase: occasional resets, mixed ids, changing operands.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      reset  = ($urandom_range(0, 99) != 0);
      start  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0, 1:    iseId = 8'h0C;
        2:       iseId = 8'h0B;
        default: iseId = 8'($urandom);
      endcase
      valueA = $urandom;
      valueB = $urandom;
    end
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    repeat (8) @(negedge clock);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
